rx_port_sched: RTL and testbench
================================

# rx_port_sched

Frame-level scheduler for the four PHY receive FIFOs that feed the MAC decoder. It ranks ports by FIFO fill urgency, breaks ties round-robin, and promotes starved ports. It holds one grant for a whole frame until the decoder reports the frame done, and runs a watchdog that reclaims a stuck grant. It sits between the PHY RX FIFO status flags and the decoder's port-select input.

## Interface
- SYNC_STAGES, 2, synchronizer depth for `fifo_half` and `fifo_afull` (write-clock-domain flags); legal values 2–3.
- STARVE_LIMIT, 8, number of lost arbitrations after which a waiting port overrides urgency; range 1–15.
- TIMEOUT_CYC, 4095, maximum cycles a grant may be held without `frame_done`; range 1–4095 (12-bit counter).

Ports:
- clk  in  1  sole clock.
- arst  in  1  asynchronous reset, active-high.
- fifo_aempty  in  4  per-port almost-empty; already in `clk` domain.
- fifo_half  in  4  per-port half-full; asynchronous, synchronized internally.
- fifo_afull  in  4  per-port almost-full; asynchronous, synchronized internally.
- port_mask  in  4  1 = port eligible; 0 = never granted.
- sched_req  in  1  decoder idle, and header/body FIFOs have room for one maximum-size frame.
- frame_done  in  1  one-cycle pulse from the decoder at end of the granted frame.
- grant_valid  out  1  a port is granted.
- grant_port  out  2  granted port index; stable while `grant_valid` = 1.
- timeout  out  1  one-cycle pulse when the watchdog reclaims a grant.
- starved  out  4  per-port flag: wait counter ≥ STARVE_LIMIT.

## Operation
- Urgency of port i, computed from synchronized flags, for unmasked ports only:
  - 3 if afull_s[i];
  - else 2 if half_s[i];
  - else 1 if ~fifo_aempty[i];
  - else 0 (ineligible).
- States: IDLE, GRANT, HOLDOFF.
- IDLE:
  - Arbitration fires when `sched_req` = 1 and any port has urgency > 0.
  - The winner is registered into `grant_port`; `grant_valid` is set to 1; state → GRANT.
  - Otherwise the block stays in IDLE and outputs are unchanged.
- Winner selection:
  - If any eligible port has `starved` = 1, choose among starved ports only.
  - Otherwise choose among ports at the highest urgency level present.
  - Within the chosen set, scan from `rr_ptr`+1 mod 4 upward; the first hit wins.
  - `rr_ptr` ← winner.
- Wait counters (4-bit, one per port), updated on each arbitration:
  - The winner is cleared to 0.
  - Every other port with urgency > 0 increments, saturating at 15.
  - Ports with urgency 0 hold their value.
  - `starved[i]` = (wcnt[i] ≥ STARVE_LIMIT).
- GRANT:
  - The watchdog counter starts at 0 on entry and increments every cycle.
  - On `frame_done`: `grant_valid` ← 0, state → HOLDOFF.
  - If the watchdog reaches TIMEOUT_CYC−1 without `frame_done`: `grant_valid` ← 0, `timeout` pulses, state → HOLDOFF.
  - If `frame_done` and watchdog expiry coincide, `frame_done` wins and `timeout` stays 0.
  - Changes to `sched_req`, `port_mask` or the flags during GRANT do not revoke or alter the grant.
- HOLDOFF: one cycle, no grant, then → IDLE. This lets the decoder's `sched_req` and the FIFO flags settle after the frame.
- `frame_done` outside GRANT is ignored.
- Reset values while `arst` = 1:
  - `grant_valid` = 0, `grant_port` = 0, `timeout` = 0, `starved` = 0.
  - State = IDLE, `rr_ptr` = 3 (so port 0 wins first), all wait counters = 0, watchdog = 0, synchronizer flops = 0.
- Reset asserted mid-GRANT drops `grant_valid` asynchronously.

## Timing
- Arbitration latency: `sched_req` sampled high in IDLE at edge N → `grant_valid` = 1 and `grant_port` valid after edge N.
- `frame_done` at edge M → `grant_valid` = 0 after M; HOLDOFF occupies M+1; the earliest new grant is after edge M+2.
- Flag synchronization adds SYNC_STAGES cycles to `fifo_half`/`fifo_afull` before they affect urgency; `fifo_aempty` is used unsynchronized.
- Timeout: `grant_valid` is high for exactly TIMEOUT_CYC cycles; `timeout` is high in the first cycle after `grant_valid` falls.
- `starved` is registered and updates the cycle after each arbitration.
- Minimum frame-to-frame spacing: 3 cycles (grant, done, holdoff), plus the decoder frame time.

## Test plan
- Reset, mask = 4'hF, `fifo_aempty` = 4'b0000, `sched_req` pulsing, `frame_done` 5 cycles after each grant → grants 0, 1, 2, 3, 0 in order.
- `fifo_aempty` = 4'b0000, `fifo_afull[2]` = 1 held ≥ 3 cycles → the next grant is port 2 regardless of `rr_ptr`.
- Port 3 at urgency 1, port 0 at urgency 3 continuously, STARVE_LIMIT = 8 → after 8 consecutive port-0 grants, `starved[3]` = 1 and the 9th grant is port 3; then `starved[3]` = 0.
- `port_mask` = 4'b1011, all ports afull → port 2 is never granted over 20 arbitrations.
- Grant issued and `frame_done` withheld, TIMEOUT_CYC = 16 → `grant_valid` high for 16 cycles, one-cycle `timeout`, next grant no earlier than 2 cycles later; `frame_done` coincident with expiry → `timeout` = 0.
- `arst` pulsed mid-GRANT → `grant_valid` = 0 immediately; after release, the first grant goes to port 0 with all counters cleared.

Source files
------------

// File: rtl/rx_port_sched.sv
// rx_port_sched: frame-level scheduler for the four PHY RX FIFOs feeding the MAC
// decoder. Ranks ports by fill urgency, breaks ties round-robin, promotes starved
// ports, holds each grant for a whole frame and reclaims stuck grants by watchdog.
module rx_port_sched #(
  parameter int SYNC_STAGES  = 2,
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT_CYC  = 4095
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [3:0] fifo_aempty,
  input  logic [3:0] fifo_half,
  input  logic [3:0] fifo_afull,
  input  logic [3:0] port_mask,
  input  logic       sched_req,
  input  logic       frame_done,
  output logic       grant_valid,
  output logic [1:0] grant_port,
  output logic       timeout,
  output logic [3:0] starved
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam logic [11:0] WD_LAST    = 12'(TIMEOUT_CYC - 1);
  localparam logic [3:0]  STARVE_THR = 4'(STARVE_LIMIT);

  state_t                        state_reg, state_next;
  logic [SYNC_STAGES-1:0][3:0]   half_sync_reg;
  logic [SYNC_STAGES-1:0][3:0]   afull_sync_reg;
  logic [3:0]                    half_s, afull_s;
  logic [3:0][1:0]               urg;
  logic [3:0]                    elig;
  logic [3:0]                    top_set, starve_set, cand;
  logic [1:0]                    max_urg, winner, scan_idx;
  logic                          found;

  logic                          grant_valid_reg, grant_valid_next;
  logic [1:0]                    grant_port_reg, grant_port_next;
  logic                          timeout_reg, timeout_next;
  logic [3:0]                    starved_reg, starved_next;
  logic [1:0]                    rr_ptr_reg, rr_ptr_next;
  logic [3:0][3:0]               wcnt_reg, wcnt_next;
  logic [11:0]                   wd_reg, wd_next;

  // Retime the write-domain half/afull flags through a SYNC_STAGES-deep chain.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      half_sync_reg  <= '0;
      afull_sync_reg <= '0;
    end else begin
      half_sync_reg  <= {half_sync_reg[SYNC_STAGES-2:0], fifo_half};
      afull_sync_reg <= {afull_sync_reg[SYNC_STAGES-2:0], fifo_afull};
    end
  end

  assign half_s  = half_sync_reg[SYNC_STAGES-1];
  assign afull_s = afull_sync_reg[SYNC_STAGES-1];

  // Per-port urgency: masked ports are always 0; aempty is already in clk domain.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_urg
      assign urg[gi]  = !port_mask[gi]    ? 2'd0 :
                        afull_s[gi]       ? 2'd3 :
                        half_s[gi]        ? 2'd2 :
                        !fifo_aempty[gi]  ? 2'd1 : 2'd0;
      assign elig[gi] = |urg[gi];
    end
  endgenerate

  // Candidate set (starved ports first, else top urgency) and round-robin scan.
  always_comb begin
    max_urg = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (urg[i] > max_urg) max_urg = urg[i];
    end
    top_set = '0;
    for (int i = 0; i < 4; i++) begin
      top_set[i] = elig[i] && (urg[i] == max_urg);
    end
    starve_set = starved_reg & elig;
    cand       = (|starve_set) ? starve_set : top_set;
    winner     = rr_ptr_reg;
    found      = 1'b0;
    scan_idx   = rr_ptr_reg;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = rr_ptr_reg + 2'(k);
      if (!found && cand[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state and datapath updates: arbitration, watchdog, wait counters.
  always_comb begin
    state_next       = state_reg;
    grant_valid_next = grant_valid_reg;
    grant_port_next  = grant_port_reg;
    timeout_next     = 1'b0;
    starved_next     = starved_reg;
    rr_ptr_next      = rr_ptr_reg;
    wcnt_next        = wcnt_reg;
    wd_next          = wd_reg;
    case (state_reg)
      ST_IDLE: begin
        if (sched_req && (|elig)) begin
          state_next       = ST_GRANT;
          grant_valid_next = 1'b1;
          grant_port_next  = winner;
          rr_ptr_next      = winner;
          wd_next          = '0;
          for (int i = 0; i < 4; i++) begin
            if (2'(i) == winner)                      wcnt_next[i] = 4'd0;
            else if (elig[i] && wcnt_reg[i] != 4'hF)  wcnt_next[i] = wcnt_reg[i] + 4'd1;
            starved_next[i] = (wcnt_next[i] >= STARVE_THR);
          end
        end
      end
      ST_GRANT: begin
        // frame_done takes priority over a coincident watchdog expiry.
        if (frame_done) begin
          state_next       = ST_HOLDOFF;
          grant_valid_next = 1'b0;
        end else if (wd_reg == WD_LAST) begin
          state_next       = ST_HOLDOFF;
          grant_valid_next = 1'b0;
          timeout_next     = 1'b1;
        end else begin
          wd_next = wd_reg + 12'd1;
        end
      end
      ST_HOLDOFF: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Registered outputs and scheduler bookkeeping.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      grant_valid_reg <= 1'b0;
      grant_port_reg  <= 2'd0;
      timeout_reg     <= 1'b0;
      starved_reg     <= '0;
      rr_ptr_reg      <= 2'd3;
      wcnt_reg        <= '0;
      wd_reg          <= '0;
    end else begin
      grant_valid_reg <= grant_valid_next;
      grant_port_reg  <= grant_port_next;
      timeout_reg     <= timeout_next;
      starved_reg     <= starved_next;
      rr_ptr_reg      <= rr_ptr_next;
      wcnt_reg        <= wcnt_next;
      wd_reg          <= wd_next;
    end
  end

  assign grant_valid = grant_valid_reg;
  assign grant_port  = grant_port_reg;
  assign timeout     = timeout_reg;
  assign starved     = starved_reg;

endmodule

// File: tb/tb_rx_port_sched.sv
// tb_rx_port_sched: table-driven vectors, directed corner sequences and random
// stimulus, all checked each cycle against an abstract frame-scheduler model.
module tb_rx_port_sched;
  localparam int SYNC = 2;
  localparam int SLIM = 8;
  localparam int TCYC = 16;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [3:0] fifo_aempty = 4'hF;
  logic [3:0] fifo_half = 4'h0;
  logic [3:0] fifo_afull = 4'h0;
  logic [3:0] port_mask = 4'hF;
  logic       sched_req = 1'b0;
  logic       frame_done = 1'b0;
  logic       grant_valid;
  logic [1:0] grant_port;
  logic       timeout;
  logic [3:0] starved;

  rx_port_sched #(.SYNC_STAGES(SYNC), .STARVE_LIMIT(SLIM), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .arst(arst), .fifo_aempty(fifo_aempty), .fifo_half(fifo_half),
    .fifo_afull(fifo_afull), .port_mask(port_mask), .sched_req(sched_req),
    .frame_done(frame_done), .grant_valid(grant_valid), .grant_port(grant_port),
    .timeout(timeout), .starved(starved)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 = waiting for a request, 1 = frame held, 2 = settle.
  int         m_phase;
  bit         m_gv;
  int         m_gp;
  bit         m_to;
  int         m_rr;
  int         m_held;
  int         m_wait[4];
  logic [3:0] q_half[$];
  logic [3:0] q_afull[$];

  typedef struct {
    logic [3:0] mask;
    logic [3:0] aempty;
    logic [3:0] half;
    logic [3:0] afull;
    bit         exp_valid;
    int         exp_port;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0; m_gv = 0; m_gp = 0; m_to = 0; m_rr = 3; m_held = 0;
    for (int i = 0; i < 4; i++) m_wait[i] = 0;
    q_half.delete();
    q_afull.delete();
  endfunction

  function automatic int exp_starved();
    int s = 0;
    for (int i = 0; i < 4; i++) if (m_wait[i] >= SLIM) s |= (1 << i);
    return s;
  endfunction

  // One clock edge of the scheduler, evaluated from the inputs present at that edge.
  function automatic void model_edge();
    logic [3:0] hs, as;
    int u[4];
    int best, pick;
    bit any_st;
    hs = (q_half.size() >= SYNC) ? q_half[q_half.size() - SYNC] : 4'h0;
    as = (q_afull.size() >= SYNC) ? q_afull[q_afull.size() - SYNC] : 4'h0;
    q_half.push_back(fifo_half);
    q_afull.push_back(fifo_afull);
    if (q_half.size() > 8) begin void'(q_half.pop_front()); void'(q_afull.pop_front()); end
    m_to = 0;
    case (m_phase)
      0: begin
        best = 0; any_st = 0;
        for (int i = 0; i < 4; i++) begin
          u[i] = !port_mask[i] ? 0 : as[i] ? 3 : hs[i] ? 2 : !fifo_aempty[i] ? 1 : 0;
          if (u[i] > best) best = u[i];
        end
        for (int i = 0; i < 4; i++) if (u[i] > 0 && m_wait[i] >= SLIM) any_st = 1;
        if (sched_req && best > 0) begin
          pick = -1;
          for (int k = 1; k <= 4; k++) begin
            int p;
            p = (m_rr + k) % 4;
            if (pick < 0 && (any_st ? (u[p] > 0 && m_wait[p] >= SLIM) : (u[p] == best))) pick = p;
          end
          for (int i = 0; i < 4; i++) begin
            if (i == pick) m_wait[i] = 0;
            else if (u[i] > 0 && m_wait[i] < 15) m_wait[i]++;
          end
          m_rr = pick; m_gv = 1; m_gp = pick; m_held = 0; m_phase = 1;
        end
      end
      1: begin
        m_held++;
        if (frame_done) begin m_gv = 0; m_phase = 2; end
        else if (m_held == TCYC) begin m_gv = 0; m_to = 1; m_phase = 2; end
      end
      default: m_phase = 0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!arst) model_edge();
    #1;
    check("grant_valid", grant_valid, m_gv);
    if (m_gv) check("grant_port", grant_port, m_gp);
    check("timeout", timeout, m_to);
    check("starved", starved, exp_starved());
  endtask

  task automatic do_reset();
    arst = 1'b1;
    model_reset();
    repeat (2) tick();
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_port", grant_port, 0);
    arst = 1'b0;
  endtask

  // Request one grant, then finish the frame 5 cycles later and pass holdoff.
  task automatic grant_frame(output bit ok, output int port);
    sched_req = 1'b1;
    tick();
    sched_req = 1'b0;
    ok = grant_valid;
    port = grant_port;
    if (ok) begin
      repeat (4) tick();
      frame_done = 1'b1;
      tick();
      frame_done = 1'b0;
      tick();
    end
  endtask

  task automatic set_flags(input logic [3:0] m, input logic [3:0] ae,
                           input logic [3:0] hf, input logic [3:0] af);
    port_mask = m; fifo_aempty = ae; fifo_half = hf; fifo_afull = af;
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit ok;
    int p;
    int hi;

    vecs[0]  = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 0};
    vecs[1]  = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 1};
    vecs[2]  = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 2};
    vecs[3]  = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 3};
    vecs[4]  = '{4'hF, 4'h0, 4'h0, 4'h0, 1'b1, 0};
    vecs[5]  = '{4'hF, 4'h0, 4'h0, 4'h4, 1'b1, 2};
    vecs[6]  = '{4'hB, 4'h0, 4'h0, 4'hF, 1'b1, 3};
    vecs[7]  = '{4'hB, 4'h0, 4'h0, 4'hF, 1'b1, 0};
    vecs[8]  = '{4'hB, 4'h0, 4'h0, 4'hF, 1'b1, 1};
    vecs[9]  = '{4'hF, 4'hE, 4'h1, 4'h0, 1'b1, 0};
    vecs[10] = '{4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 0};

    model_reset();
    do_reset();

    for (int v = 0; v < 11; v++) begin
      set_flags(vecs[v].mask, vecs[v].aempty, vecs[v].half, vecs[v].afull);
      grant_frame(ok, p);
      check($sformatf("vec%0d_valid", v), ok, vecs[v].exp_valid);
      if (vecs[v].exp_valid) check($sformatf("vec%0d_port", v), p, vecs[v].exp_port);
      $display("vec %0d: valid=%0d port=%0d", v, ok, p);
    end

    // Starvation: port 0 afull, port 3 at urgency 1.
    do_reset();
    set_flags(4'hF, 4'b0110, 4'h0, 4'b0001);
    for (int g = 0; g < 9; g++) begin
      grant_frame(ok, p);
      check("starve_valid", ok, 1);
      check("starve_port", p, (g < 8) ? 0 : 3);
      if (g == 7) check("starved3_set", starved[3], 1);
      if (g == 8) check("starved3_clr", starved[3], 0);
      $display("starve grant %0d: port=%0d starved=%b", g, p, starved);
    end

    // Masked port 2 never wins even when every port is afull.
    set_flags(4'b1011, 4'h0, 4'h0, 4'hF);
    for (int g = 0; g < 20; g++) begin
      grant_frame(ok, p);
      check("mask_valid", ok, 1);
      check("mask_port2", (p == 2) ? 1 : 0, 0);
    end
    $display("mask test: 20 arbitrations done");

    // Watchdog: frame_done withheld.
    set_flags(4'hF, 4'h0, 4'h0, 4'h0);
    sched_req = 1'b1;
    tick();
    sched_req = 1'b0;
    check("to_grant", grant_valid, 1);
    hi = 1;
    while (grant_valid && hi < 40) begin
      tick();
      if (grant_valid) hi++;
    end
    check("to_len", hi, TCYC);
    check("to_pulse", timeout, 1);
    sched_req = 1'b1;
    tick();
    check("to_holdoff", grant_valid, 0);
    check("to_pulse_end", timeout, 0);
    tick();
    check("to_regrant", grant_valid, 1);
    sched_req = 1'b0;
    $display("timeout test: high for %0d cycles", hi);
    // frame_done coincident with expiry.
    repeat (TCYC - 1) tick();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    check("coinc_timeout", timeout, 0);
    check("coinc_valid", grant_valid, 0);
    tick();
    $display("coincident done/expiry: timeout=%0d", timeout);

    // Async reset during a grant.
    sched_req = 1'b1;
    tick();
    sched_req = 1'b0;
    tick();
    check("pre_arst_valid", grant_valid, 1);
    #2 arst = 1'b1;
    #1 check("arst_drop", grant_valid, 0);
    model_reset();
    tick();
    arst = 1'b0;
    set_flags(4'hF, 4'h0, 4'h0, 4'h0);
    grant_frame(ok, p);
    check("post_arst_port", p, 0);
    check("post_arst_starved", starved, 0);
    $display("post-reset grant: port=%0d", p);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      port_mask   = 4'($urandom);
      fifo_aempty = 4'($urandom);
      fifo_half   = 4'($urandom);
      fifo_afull  = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
      sched_req   = ($urandom_range(0, 1) == 1);
      frame_done  = ($urandom_range(0, 4) == 0);
      tick();
    end
    sched_req = 1'b0;
    frame_done = 1'b0;
    $display("random phase: 600 cycles");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
